uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares one UART transmitter between NREQ byte requesters. It latches the winning requester's byte and fires a one-cycle start to the transmitter. It holds the data stable for the whole frame, then waits for the transmitter's one-cycle done pulse (rNext) before granting again. A watchdog aborts the wait if done never arrives.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 200000, CLK cycles allowed between tx_start and tx_done before abort (>16 bit periods at 9600 baud, 100 MHz)

Ports:
CLK  in  1  system clock, all logic on posedge
RST  in  1  synchronous reset, active-high
req  in  NREQ  per-requester byte-pending flags, level, held until ack
req_data  in  8*NREQ  packed bytes; requester i on bits [8*i+7:8*i]
req_ack  out  NREQ  one-hot, one-cycle pulse: byte of requester i latched
req_done  out  NREQ  one-hot, one-cycle pulse: byte of requester i fully sent
tx_err  out  1  one-cycle pulse on watchdog abort
busy  out  1  high whenever state != IDLE
tx_start  out  1  to transmitter start; one-cycle pulse
tx_data  out  8  to transmitter data; stable from START through end of WAIT
tx_done  in  1  from transmitter rNext; one-cycle pulse at end of frame

Behaviour:
- Reset (RST=1 at posedge): state=IDLE; req_ack, req_done, tx_err, tx_start=0; tx_data=8'h00; busy=0; watchdog=0; last_grant=NREQ-1, so requester 0 has first priority. Reset overrides everything, including mid-frame. tx_start is never asserted during or on the cycle after reset.
- States: IDLE, START, WAIT, DONE.
- IDLE: if any req bit is high, pick the first set index scanning last_grant+1, +2, ... modulo NREQ. At that edge:
  - tx_data <= req_data[winner]
  - grant <= winner
  - req_ack[winner] <= 1
  - state <= START
- Otherwise stay in IDLE with all pulses 0.
- START: tx_start <= 1 for exactly this one cycle; req_ack returns to 0; watchdog <= 0; state <= WAIT.
- WAIT: tx_start=0 and tx_data held. Watchdog increments each cycle.
  - tx_done=1 -> state <= DONE.
  - Else if watchdog == TIMEOUT-1 -> tx_err <= 1, last_grant <= grant, state <= IDLE; no req_done for this grant.
  - tx_done and timeout in the same cycle: tx_done wins.
- DONE: req_done[grant] <= 1 for one cycle; last_grant <= grant; state <= IDLE.
- Latency, req rising in IDLE:
  - req_ack on cycle +1.
  - tx_start on cycle +2.
  - New arbitration no earlier than 1 cycle after req_done or tx_err.
  - Gap between frames: at least 3 cycles, satisfying the transmitter's idle requirement.
- tx_done outside WAIT (IDLE, START, DONE) is ignored.
- Requester dropping req after ack has no effect on the current frame. A requester still high after ack is eligible again, but only after the others by round-robin order.
- Requester must present new req_data no earlier than the cycle after req_ack. Data is sampled only on the arbitration edge.
- Simultaneous requests: strict round-robin. With all NREQ requesting continuously, grant order is 0,1,2,...,NREQ-1,0,...
- Watchdog width: $clog2(TIMEOUT)+1 bits; it never wraps because it is cleared in START.
- At most one bit of req_ack, req_done and tx_err is high in any cycle. req_ack and req_done are never high together.

Test Plan:
- Single request: req=4'b0100, byte 8'hA5 on lane 2 -> req_ack=4'b0100 at +1, tx_start pulse at +2, tx_data=8'hA5 held. Bench pulses tx_done 100 cycles later -> req_done=4'b0100 next cycle, busy drops the cycle after.
- Round-robin: req=4'b1111 held, lanes 8'h10/8'h11/8'h12/8'h13, tx_done returned 20 cycles after each start -> tx_data sequence 10,11,12,13,10; exactly one ack per frame.
- Fairness after grant: last grant=1, req=4'b0011 -> next grant lane 0. Then, with req still 4'b0011 -> lane 1.
- Watchdog: TIMEOUT=50, no tx_done -> tx_err pulses exactly 50 cycles after tx_start, no req_done, state returns to IDLE. A late tx_done arriving in IDLE is ignored.
- Reset mid-WAIT: RST=1 for 1 cycle, 10 cycles after tx_start -> all outputs 0, busy=0, next request from lane 0 wins over lane 3.
- Spurious tx_done: pulse tx_done during IDLE and START -> no req_done, no state change beyond normal flow; frame completes only on a tx_done seen in WAIT.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte sources.
// Latches the winning byte, pulses tx_start, waits for tx_done or a watchdog abort.
module uart_tx_scheduler #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 200000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   req_done,
  output logic              tx_err,
  output logic              busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done
);

  localparam int GW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   grant_n;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   last_n;
  logic [GW-1:0]   winner;
  logic [WW-1:0]   wdog;
  logic [WW-1:0]   wdog_n;
  logic [NREQ-1:0] ack_n;
  logic [NREQ-1:0] done_n;
  logic            err_n;
  logic            start_n;
  logic [7:0]      data_n;
  logic [7:0]      lane [NREQ];

  // Nearest set request after the previous grant, scanning modulo NREQ.
  function automatic logic [GW-1:0] rr_pick(
    input logic [NREQ-1:0] r,
    input logic [GW-1:0]   last
  );
    logic [GW-1:0] w;
    int            idx;
    w = last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (r[GW'(idx)]) w = GW'(idx);
    end
    return w;
  endfunction

  // Unpack the byte lanes so the winner can select one directly.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      lane[i] = req_data[8*i +: 8];
    end
  end

  // Round-robin choice, only consumed when some request is pending.
  always_comb begin
    winner = rr_pick(req, last_grant);
  end

  // Next state and next registered outputs; pulses default low.
  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last_grant;
    wdog_n  = wdog;
    ack_n   = '0;
    done_n  = '0;
    err_n   = 1'b0;
    start_n = 1'b0;
    data_n  = tx_data;
    unique case (state)
      IDLE: begin
        if (|req) begin
          data_n  = lane[winner];
          grant_n = winner;
          ack_n   = NREQ'(1) << winner;
          state_n = START;
        end
      end
      START: begin
        start_n = 1'b1;
        wdog_n  = '0;
        state_n = WAIT;
      end
      WAIT: begin
        wdog_n = wdog + 1'b1;
        if (tx_done) begin
          done_n  = NREQ'(1) << grant;
          state_n = DONE;
        end else if (wdog == WW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          last_n  = grant;
          state_n = IDLE;
        end
      end
      DONE: begin
        last_n  = grant;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, grant history, watchdog and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NREQ - 1);
      wdog       <= '0;
      req_ack    <= '0;
      req_done   <= '0;
      tx_err     <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_n;
      wdog       <= wdog_n;
      req_ack    <= ack_n;
      req_done   <= done_n;
      tx_err     <= err_n;
      tx_start   <= start_n;
      tx_data    <= data_n;
    end
  end

  assign busy = (state != IDLE);

endmodule
